// File: rtl/l2_adaptor_pkg.sv
// l2_adaptor_pkg: shared widths, beat indexing and FSM states for the L2 cacheline adaptor
package l2_adaptor_pkg;
  localparam int LINE_W_D   = 256;
  localparam int BURST_W_D  = 64;
  localparam int BEATS      = 4;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;
endpackage

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: converts L2 line read/write requests into 4-beat memory bursts
module l2_cacheline_adaptor
  import l2_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_D,
  parameter int BURST_W = BURST_W_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  localparam logic [31:0] OFF_MASK = 32'(LINE_W / 8 - 1);
  state_t                r_state, w_next;
  logic [BEAT_IDX_W-1:0] r_k;
  logic [31:0]           r_addr;
  logic [LINE_W-1:0]     r_wdata, r_rdata;
  logic                  w_beat, w_last, w_take;
  assign w_beat = mem_resp && (r_state == ST_READ || r_state == ST_WRITE);
  assign w_last = w_beat && (r_k == BEAT_IDX_W'(BEATS - 1));
  assign w_take = r_state == ST_IDLE && (pmem_read || pmem_write);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == ST_IDLE) ? (pmem_read ? ST_READ : pmem_write ? ST_WRITE : ST_IDLE) :
             (r_state == ST_DONE) ? ST_IDLE :
             w_last ? ST_DONE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_beat) r_k <= r_k + 1'b1;
      if (w_take) r_addr <= pmem_address & ~OFF_MASK;
      if (w_take && !pmem_read) r_wdata <= pmem_wdata;
      if (w_beat && r_state == ST_READ) r_rdata[int'(r_k)*BURST_W +: BURST_W] <= mem_rdata;
    end
  end
  assign pmem_rdata  = r_rdata;
  assign pmem_resp   = r_state == ST_DONE;
  assign mem_read    = r_state == ST_READ;
  assign mem_write   = r_state == ST_WRITE;
  assign mem_address = r_addr;
  assign mem_wdata   = r_wdata[int'(r_k)*BURST_W +: BURST_W];
endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor: scoreboard bench driving L2 requests and a beat-level memory model
module tb_l2_cacheline_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pmem_address = '0;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [LW-1:0] pmem_wdata = '0;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [BW-1:0] mem_wdata;
  logic [BW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  int total = 0;
  int bad = 0;
  logic [LW-1:0] q_line[$];
  logic [BW-1:0] q_beat[$];
  logic [LW-1:0] last_line = '0;

  l2_cacheline_adaptor #(.LINE_W(LW), .BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line;
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_idle_outs(input string nm);
    total++;
    if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL %s: resp/rd/wr got %b%b%b want 000", nm, pmem_resp, mem_read, mem_write);
    end
  endtask

  task automatic do_xact(input bit wr, input logic [31:0] a, input logic [LW-1:0] line,
                         input int gap, input bit stray_done);
    logic [LW-1:0] exp_line;
    logic [BW-1:0] exp_beat;
    if (wr) begin
      for (int k = 0; k < 4; k++) q_beat.push_back(line[k*BW +: BW]);
      pmem_wdata = line;
      pmem_write = 1'b1;
    end else begin
      q_line.push_back(line);
      pmem_wdata = rnd_line();
      pmem_read = 1'b1;
    end
    pmem_address = a;
    tick;
    pmem_address = $urandom;
    pmem_wdata = rnd_line();
    total++;
    if (mem_read !== !wr || mem_write !== wr) begin
      bad++;
      $display("FAIL latency: rd/wr got %b%b want %b%b", mem_read, mem_write, !wr, wr);
    end
    total++;
    if (mem_address !== (a & 32'hFFFF_FFE0)) begin
      bad++;
      $display("FAIL mem_address: got %h want %h", mem_address, a & 32'hFFFF_FFE0);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        mem_resp = 1'b0;
        mem_rdata = {$urandom, $urandom};
        tick;
        total++;
        if (pmem_resp !== 1'b0 || mem_read !== !wr || mem_write !== wr) begin
          bad++;
          $display("FAIL gap_hold: resp/rd/wr got %b%b%b want 0%b%b", pmem_resp, mem_read, mem_write, !wr, wr);
        end
      end
      if (wr) begin
        exp_beat = q_beat.pop_front();
        total++;
        if (mem_wdata !== exp_beat) begin
          bad++;
          $display("FAIL mem_wdata beat%0d: got %h want %h", k, mem_wdata, exp_beat);
        end
      end
      mem_resp = 1'b1;
      mem_rdata = wr ? {$urandom, $urandom} : line[k*BW +: BW];
      tick;
      mem_resp = 1'b0;
      if (k < 3) begin
        total++;
        if (pmem_resp !== 1'b0) begin
          bad++;
          $display("FAIL early_resp beat%0d: got %b want 0", k, pmem_resp);
        end
      end
    end
    total++;
    if (pmem_resp !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL done: resp/rd/wr got %b%b%b want 100", pmem_resp, mem_read, mem_write);
    end
    if (!wr) last_line = q_line.pop_front();
    exp_line = last_line;
    total++;
    if (pmem_rdata !== exp_line) begin
      bad++;
      $display("FAIL pmem_rdata: got %h want %h", pmem_rdata, exp_line);
    end
    if (stray_done) begin
      mem_resp = 1'b1;
      mem_rdata = {$urandom, $urandom};
    end
    tick;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    chk_idle_outs("after_done");
    total++;
    if (pmem_rdata !== last_line) begin
      bad++;
      $display("FAIL rdata_hold: got %h want %h", pmem_rdata, last_line);
    end
  endtask

  task automatic chk_zero(input string nm);
    total++;
    if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        mem_address !== 32'h0 || mem_wdata !== '0 || pmem_rdata !== '0) begin
      bad++;
      $display("FAIL %s: resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h want all 0",
               nm, pmem_resp, mem_read, mem_write, mem_address, mem_wdata, pmem_rdata);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick;
    chk_zero("reset_state");
    rst_n = 1'b1;
    tick;
    chk_idle_outs("post_reset_idle");
  endtask

  task automatic test_read;
    do_xact(1'b0, 32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b0);
    do_xact(1'b0, 32'hDEAD_BEFF, rnd_line(), 0, 1'b0);
  endtask

  task automatic test_write;
    do_xact(1'b1, 32'h8000_004C, {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                                  64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 0, 1'b0);
  endtask

  task automatic test_gapped;
    do_xact(1'b0, 32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 2, 1'b0);
    do_xact(1'b1, 32'h1234_5678, rnd_line(), 2, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_xact(1'b1, 32'h0000_2000, rnd_line(), 0, 1'b0);
    do_xact(1'b0, 32'h0000_3000, rnd_line(), 1, 1'b0);
    do_xact(1'b1, 32'h0000_4000, rnd_line(), 0, 1'b0);
  endtask

  task automatic test_priority;
    pmem_write = 1'b1;
    do_xact(1'b0, 32'h0000_5000, rnd_line(), 0, 1'b0);
  endtask

  task automatic test_reset_mid;
    pmem_read = 1'b1;
    pmem_address = 32'h0000_7777;
    tick;
    for (int k = 0; k < 2; k++) begin
      mem_resp = 1'b1;
      mem_rdata = {$urandom, $urandom};
      tick;
    end
    mem_resp = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("reset_mid_async");
    last_line = '0;
    pmem_read = 1'b0;
    tick;
    tick;
    chk_zero("reset_mid_held");
    rst_n = 1'b1;
    tick;
    chk_idle_outs("reset_mid_release");
    do_xact(1'b0, 32'h0000_8888, rnd_line(), 0, 1'b0);
  endtask

  task automatic test_stray;
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1;
      mem_rdata = {$urandom, $urandom};
      tick;
      chk_idle_outs("stray_idle");
      total++;
      if (pmem_rdata !== last_line) begin
        bad++;
        $display("FAIL stray_rdata: got %h want %h", pmem_rdata, last_line);
      end
    end
    mem_resp = 1'b0;
    do_xact(1'b0, 32'h0000_9999, rnd_line(), 0, 1'b1);
    do_xact(1'b0, 32'h0000_AAAA, rnd_line(), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_gapped();
    test_back_to_back();
    test_priority();
    test_reset_mid();
    test_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
